inst_issuer: RTL and testbench
==============================

# inst_issuer

Instruction issuer that drives the 21-bit instruction port of the processing core. A host writes instructions into an internal FIFO. On a start command the block streams them to the core over a valid/ready handshake, one instruction per accepted transfer, and counts the transfers. It sits directly upstream of the core: o_inst/o_valid connect to the core's i_inst/i_valid, and i_ready connects to the core's o_ready.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- W, 21, instruction width
- i_clk  in  1  clock; all state updates on rising edge
- i_rsn  in  1  reset, asynchronous, active-low
- i_wr  in  1  host write strobe
- i_wdata  in  W  instruction to enqueue
- o_full  out  1  FIFO full (registered)
- o_empty  out  1  FIFO empty (registered)
- o_err  out  1  sticky: write attempted while full
- i_start  in  1  start draining FIFO to the core (level sampled each edge)
- o_busy  out  1  high in RUN state
- o_done  out  1  one-cycle pulse when a run completes
- o_inst  out  W  instruction to core; held stable while o_valid && !i_ready
- o_valid  out  1  o_inst valid
- i_ready  in  1  core accepts o_inst this cycle
- o_count  out  8  transfers since last start; wraps 255 -> 0

## Operation
- Reset (i_rsn=0, async) sets: FIFO pointers 0, o_empty=1, o_full=0, o_err=0, o_busy=0, o_done=0, o_valid=0, o_inst=0, o_count=0, state IDLE.
- FIFO write: on an edge with i_wr=1 && o_full=0, i_wdata is enqueued. If i_wr=1 && o_full=1, the write is dropped and o_err is set. Writes are accepted in every state.
- Output stage: a single register (o_inst, o_valid).
  - Transfer occurs on an edge with o_valid=1 && i_ready=1.
  - In RUN, the register loads the FIFO head (pop) when o_valid=0 or a transfer occurs, provided the FIFO is non-empty. Result: back-to-back issue, one instruction per cycle.
  - If no load occurs, o_valid clears on a transfer and otherwise holds.
  - o_inst is never changed while o_valid=1 && i_ready=0.
- Simultaneous write and pop: allowed in the same edge; occupancy is unchanged. When o_full=1, a write is rejected even if a pop occurs in the same edge.
- FSM:
  - IDLE: o_valid stays 0. i_start=1 -> RUN, clears o_count and o_err.
  - RUN: o_busy=1; i_start is ignored. Transition to DONE on an edge where, after that edge's pop/transfer, the FIFO is empty and the output register is empty.
  - DONE: o_done=1 for exactly one cycle, o_busy=0 -> IDLE.
- Instructions written during RUN before the FIFO drains are issued in the same run.
- o_count increments by 1 on each transfer, modulo 256.
- i_ready while o_valid=0 has no effect.

## Timing
- A write at edge j is poppable at edge j+1. o_empty and o_full update at the same edge as the write or pop.
- i_start sampled at edge k -> o_busy=1 after k. If the FIFO is non-empty, the first o_valid=1 comes after k+1.
- With i_ready held at 1 and N queued instructions, o_valid is high for N consecutive cycles after edges k+1..k+N.
  - Entry to DONE is at edge k+N+1; o_done is high between edges k+N+1 and k+N+2.
- Start with an empty FIFO: RUN after k, DONE after k+1, IDLE after k+2; no o_valid.
- Handshake stalls (i_ready=0) extend the run by the stall count; there is no timeout.
- Reset asserted mid-run: outputs reach reset values immediately; queued instructions are discarded.

## Test plan
- Reset values: assert i_rsn=0 mid-stream with o_valid=1 -> o_valid, o_busy, o_count, o_err and o_inst immediately read 0; o_empty=1.
- Burst issue: write 0x00001, 0x00002, 0x00003, then pulse i_start with i_ready=1.
  - o_inst shows 1, 2, 3 on three consecutive cycles starting two cycles after start.
  - o_done pulses one cycle after the last transfer; o_count=3.
- Backpressure: with 2 queued instructions, hold i_ready=0 for 5 cycles -> o_inst=first instruction, stable, with o_valid=1; after release, both transfer in order and o_count=2.
- Full/overflow: DEPTH=8; write 9 instructions while IDLE -> o_full=1 after the 8th write and o_err=1 after the 9th.
  - Start -> exactly 8 transfers, in write order.
  - The next i_start clears o_err.
- Write during run: 1 queued, start with i_ready toggling 1/0; write 0x1ABCD while the first is stalled -> 2 transfers, no o_done between them, o_count=2.
- Wrap: run 256 instructions (refilling during RUN) -> o_count returns to 0; 257 -> o_count=1.

Source files
------------

// File: rtl/inst_issuer.sv
// Instruction issuer: host-filled FIFO streamed to the core over valid/ready on start, with transfer count.
// Latency: first o_valid one cycle after start is sampled; back-to-back issue, one instruction per cycle.
// Backpressure: i_ready=0 holds o_inst/o_valid; writes while full are dropped and flagged on o_err.
module inst_issuer #(
    parameter int DEPTH = 8,
    parameter int W     = 21
) (
    input  logic         i_clk,
    input  logic         i_rsn,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_err,
    input  logic         i_start,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_inst,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [7:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, cnt_nxt;
    logic          push, pop, xfer, start_run, valid_nxt;

    assign xfer      = o_valid && i_ready;
    assign push      = i_wr && !o_full;
    // Refill the output register whenever it is empty or being drained this edge.
    assign pop       = (state == RUN) && !o_empty && (!o_valid || i_ready);
    assign start_run = (state == IDLE) && i_start;
    assign valid_nxt = pop || (o_valid && !i_ready);
    assign cnt_nxt   = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
            o_err   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt     <= cnt_nxt;
            o_full  <= (cnt_nxt == FULL_CNT);
            o_empty <= (cnt_nxt == '0);
            if (i_wr && o_full)
                o_err <= 1'b1;
            else if (start_run)
                o_err <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            o_inst  <= '0;
            o_valid <= 1'b0;
            o_count <= '0;
        end else begin
            if (pop) begin
                o_inst  <= mem[rd_ptr];
                o_valid <= 1'b1;
            end else if (xfer) begin
                o_valid <= 1'b0;
            end
            if (start_run)
                o_count <= '0;
            else if (xfer)
                o_count <= o_count + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = RUN;
            // Late writes keep the run alive: cnt_nxt already includes this edge's push.
            RUN:     if ((cnt_nxt == '0) && !valid_nxt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = (state == RUN);
    assign o_done = (state == DONE);
endmodule

// File: tb/tb_inst_issuer.sv
// Directed bench for inst_issuer: reset, burst, backpressure, overflow, write-during-run, count wrap.
module tb_inst_issuer;
    logic        i_clk = 1'b0;
    logic        i_rsn;
    logic        i_wr;
    logic [20:0] i_wdata;
    logic        o_full, o_empty, o_err;
    logic        i_start;
    logic        o_busy, o_done;
    logic [20:0] o_inst;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_count;

    int checks = 0;
    int errors = 0;

    inst_issuer #(.DEPTH(8), .W(21)) dut (
        .i_clk(i_clk), .i_rsn(i_rsn), .i_wr(i_wr), .i_wdata(i_wdata),
        .o_full(o_full), .o_empty(o_empty), .o_err(o_err),
        .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_inst(o_inst), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input logic [20:0] d);
        i_wr    = 1'b1;
        i_wdata = d;
        tick();
        i_wr    = 1'b0;
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // n instructions: 4 prefilled, rest written one per cycle while RUN drains one per cycle.
    task automatic run_stream(input int n, input logic [20:0] base);
        i_ready = 1'b1;
        for (int j = 0; j < 4; j++) wr(base + 21'(j));
        start_pulse();
        for (int j = 0; j < n; j++) begin
            if (j < n - 4) begin
                i_wr    = 1'b1;
                i_wdata = base + 21'(j + 4);
            end else begin
                i_wr = 1'b0;
            end
            tick();
            chk("stream_inst", 32'(o_inst), 32'(base + 21'(j)));
        end
        i_wr = 1'b0;
        chk("stream_cnt_before", 32'(o_count), 32'((n - 1) % 256));
        chk("stream_err", 32'(o_err), 32'd0);
        tick();
        chk("stream_done", 32'(o_done), 32'd1);
        chk("stream_cnt_final", 32'(o_count), 32'(n % 256));
        tick();
    endtask

    initial begin
        i_rsn = 1'b0; i_wr = 1'b0; i_wdata = '0; i_start = 1'b0; i_ready = 1'b0;
        #23;
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full",  32'(o_full),  32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_done",  32'(o_done),  32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        i_rsn = 1'b1;
        tick();

        // Burst issue
        wr(21'h00001); wr(21'h00002); wr(21'h00003);
        chk("burst_nonempty", 32'(o_empty), 32'd0);
        i_ready = 1'b1;
        start_pulse();
        chk("burst_busy",  32'(o_busy),  32'd1);
        chk("burst_noval", 32'(o_valid), 32'd0);
        for (int j = 1; j <= 3; j++) begin
            tick();
            chk("burst_valid", 32'(o_valid), 32'd1);
            chk("burst_inst",  32'(o_inst),  32'(j));
            chk("burst_nodone", 32'(o_done), 32'd0);
        end
        tick();
        chk("burst_done",  32'(o_done),  32'd1);
        chk("burst_idlev", 32'(o_valid), 32'd0);
        chk("burst_count", 32'(o_count), 32'd3);
        tick();
        chk("burst_done_pulse", 32'(o_done), 32'd0);
        chk("burst_empty", 32'(o_empty), 32'd1);

        // Empty start: RUN, DONE, IDLE
        start_pulse();
        chk("empty_busy", 32'(o_busy), 32'd1);
        tick();
        chk("empty_done", 32'(o_done), 32'd1);
        chk("empty_noval", 32'(o_valid), 32'd0);
        tick();
        chk("empty_idle", 32'(o_busy | o_done), 32'd0);

        // Backpressure
        wr(21'h0A001); wr(21'h0A002);
        i_ready = 1'b0;
        start_pulse();
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_inst",  32'(o_inst),  32'h0A001);
        end
        i_ready = 1'b1;
        tick();
        chk("bp_second", 32'(o_inst), 32'h0A002);
        chk("bp_count1", 32'(o_count), 32'd1);
        tick();
        chk("bp_done",  32'(o_done),  32'd1);
        chk("bp_count", 32'(o_count), 32'd2);
        tick();

        // Full / overflow
        i_ready = 1'b0;
        for (int j = 0; j < 9; j++) begin
            wr(21'h00100 + 21'(j));
            if (j == 7) begin
                chk("ovf_full8", 32'(o_full), 32'd1);
                chk("ovf_noerr", 32'(o_err),  32'd0);
            end
        end
        chk("ovf_err", 32'(o_err), 32'd1);
        i_ready = 1'b1;
        start_pulse();
        chk("ovf_err_clr", 32'(o_err), 32'd0);
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("ovf_inst", 32'(o_inst), 32'h00100 + 32'(j));
        end
        tick();
        chk("ovf_done",  32'(o_done),  32'd1);
        chk("ovf_count", 32'(o_count), 32'd8);
        tick();

        // Write during run
        wr(21'h00055);
        i_ready = 1'b0;
        start_pulse();
        tick();
        chk("wdr_first", 32'(o_inst), 32'h00055);
        wr(21'h1ABCD);
        chk("wdr_stall_hold", 32'(o_inst), 32'h00055);
        chk("wdr_nodone0", 32'(o_done | !o_busy), 32'd0);
        i_ready = 1'b1;
        tick();
        chk("wdr_second", 32'(o_inst), 32'h1ABCD);
        chk("wdr_nodone1", 32'(o_done), 32'd0);
        i_ready = 1'b0;
        tick();
        chk("wdr_hold2", 32'(o_valid), 32'd1);
        chk("wdr_nodone2", 32'(o_done), 32'd0);
        i_ready = 1'b1;
        tick();
        chk("wdr_done",  32'(o_done),  32'd1);
        chk("wdr_count", 32'(o_count), 32'd2);
        tick();

        // Count wrap
        run_stream(256, 21'h02000);
        run_stream(257, 21'h03000);

        // Async reset mid-run with o_valid=1 and o_err=1
        for (int j = 0; j < 9; j++) wr(21'h00700 + 21'(j));
        i_ready = 1'b1;
        start_pulse();
        tick();
        tick();
        chk("mr_count1", 32'(o_count), 32'd1);
        i_ready = 1'b0;
        for (int j = 0; j < 3; j++) wr(21'h00800 + 21'(j));
        chk("mr_err",   32'(o_err),   32'd1);
        chk("mr_valid", 32'(o_valid), 32'd1);
        #2 i_rsn = 1'b0;
        #1;
        chk("mr_rst_valid", 32'(o_valid), 32'd0);
        chk("mr_rst_busy",  32'(o_busy),  32'd0);
        chk("mr_rst_count", 32'(o_count), 32'd0);
        chk("mr_rst_err",   32'(o_err),   32'd0);
        chk("mr_rst_inst",  32'(o_inst),  32'd0);
        chk("mr_rst_empty", 32'(o_empty), 32'd1);
        chk("mr_rst_full",  32'(o_full),  32'd0);
        i_rsn = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
